emc_pmem_ctrl: RTL and testbench

Program-memory fetch controller for the EMC08 core. It accepts CPU opcode/operand fetch requests and serves each one from one of two sources:
- the internal 4096x8 program ROM, or
- the external bus, using the P0 multiplexed address/data port, the P2 high-address port and PSEN_b.

The source is chosen by EA_b and the fetch address. It sits between the CPU fetch unit and the ROM macro / port pad logic in emc_top.

---
 rtl/emc_pmem_ctrl.sv | 156 +++++++++++++++
 tb/tb_emc_pmem_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/emc_pmem_ctrl.sv
// EMC08 program fetch: internal ROM (ack 2 edges after accept) or external P0/P2/PSEN_b bus (ack EXT_WAIT+2 edges after).
// One fetch in flight; req is ignored while busy. `EMC_PMC_EXT_WAIT_EN adds pmc_wait_i to stretch PSEN_b.
module emc_pmem_ctrl #(
    parameter int ROM_AW   = 12,
    parameter int EXT_WAIT = 2
) (
    input  logic              pmc_clock_i,
    input  logic              pmc_reset_i,
    input  logic              pmc_req_i,
    input  logic [15:0]       pmc_addr_i,
    input  logic              pmc_ea_b_i,
    output logic              pmc_ack_o,
    output logic [7:0]        pmc_data_o,
    output logic              pmc_busy_o,
    output logic              pmc_rom_cs_o,
    output logic [ROM_AW-1:0] pmc_rom_addr_o,
    input  logic [7:0]        pmc_rom_data_i,
    output logic              pmc_ale_o,
    output logic              pmc_psen_b_o,
    output logic [7:0]        pmc_p0_a_o,
    output logic [7:0]        pmc_p0_en_o,
    output logic [7:0]        pmc_p2_a_o,
`ifdef EMC_PMC_EXT_WAIT_EN
    input  logic [7:0]        pmc_p0_y_i,
    input  logic              pmc_wait_i
`else
    input  logic [7:0]        pmc_p0_y_i
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_RD,
        S_ROM_CAP,
        S_EXT_ALE,
        S_EXT_PSEN
    } state_t;

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic [7:0]        data_q, data_d;
    logic              rom_cs_q, rom_cs_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              ale_q, ale_d;
    logic              psen_b_q, psen_b_d;
    logic [7:0]        p0_a_q, p0_a_d;
    logic [7:0]        p0_en_q, p0_en_d;
    logic [7:0]        p2_a_q, p2_a_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_int;
    logic              ext_hold;

    // Internal ROM only when EA_b allows it and the address falls inside the ROM window.
    assign is_int = pmc_ea_b_i && ((pmc_addr_i >> ROM_AW) == 16'd0);

`ifdef EMC_PMC_EXT_WAIT_EN
    assign ext_hold = pmc_wait_i;
`else
    assign ext_hold = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        data_d     = data_q;
        rom_cs_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        ale_d      = 1'b0;
        psen_b_d   = psen_b_q;
        p0_a_d     = p0_a_q;
        p0_en_d    = p0_en_q;
        p2_a_d     = p2_a_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pmc_req_i) begin
                    if (is_int) begin
                        rom_cs_d   = 1'b1;
                        rom_addr_d = pmc_addr_i[ROM_AW-1:0];
                        state_d    = S_ROM_RD;
                    end else begin
                        ale_d   = 1'b1;
                        p0_a_d  = pmc_addr_i[7:0];
                        p2_a_d  = pmc_addr_i[15:8];
                        p0_en_d = 8'hFF;
                        state_d = S_EXT_ALE;
                    end
                end
            end
            S_ROM_RD: state_d = S_ROM_CAP;
            S_ROM_CAP: begin
                data_d  = pmc_rom_data_i;
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_EXT_ALE: begin
                // Release P0 so the external memory can drive data while PSEN_b is low.
                p0_en_d  = 8'h00;
                psen_b_d = 1'b0;
                cnt_d    = 4'(EXT_WAIT);
                state_d  = S_EXT_PSEN;
            end
            S_EXT_PSEN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!ext_hold) begin
                    data_d   = pmc_p0_y_i;
                    ack_d    = 1'b1;
                    psen_b_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pmc_clock_i or posedge pmc_reset_i) begin
        if (pmc_reset_i) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            data_q     <= 8'h00;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            ale_q      <= 1'b0;
            psen_b_q   <= 1'b1;
            p0_a_q     <= 8'h00;
            p0_en_q    <= 8'h00;
            p2_a_q     <= 8'h00;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            ale_q      <= ale_d;
            psen_b_q   <= psen_b_d;
            p0_a_q     <= p0_a_d;
            p0_en_q    <= p0_en_d;
            p2_a_q     <= p2_a_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pmc_ack_o      = ack_q;
    assign pmc_data_o     = data_q;
    assign pmc_busy_o     = (state_q != S_IDLE);
    assign pmc_rom_cs_o   = rom_cs_q;
    assign pmc_rom_addr_o = rom_addr_q;
    assign pmc_ale_o      = ale_q;
    assign pmc_psen_b_o   = psen_b_q;
    assign pmc_p0_a_o     = p0_a_q;
    assign pmc_p0_en_o    = p0_en_q;
    assign pmc_p2_a_o     = p2_a_q;

endmodule

// File: tb/tb_emc_pmem_ctrl.sv
// Bench for emc_pmem_ctrl: transaction-level fetch model checked every cycle, plus directed literal checks.
module tb_emc_pmem_ctrl;

    localparam int EXT_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        ea_b = 1'b1;
    logic [7:0]  p0_y = 8'h00;
    logic [7:0]  rom_q = 8'h00;
    logic [7:0]  rom [4096];
    logic        hold_now;
`ifdef EMC_PMC_EXT_WAIT_EN
    logic        wait_tb = 1'b0;
    assign hold_now = wait_tb;
`else
    assign hold_now = 1'b0;
`endif

    logic        ack, busy, rom_cs, ale, psen_b;
    logic [7:0]  data, p0_a, p0_en, p2_a;
    logic [11:0] rom_addr;

    int n_chk = 0;
    int n_err = 0;
    int n_cs = 0, n_ale = 0, n_psen = 0, n_ack = 0;
    bit cmp_en = 1'b0;

    emc_pmem_ctrl #(.ROM_AW(12), .EXT_WAIT(EXT_WAIT)) dut (
        .pmc_clock_i    (clk),
        .pmc_reset_i    (rst),
        .pmc_req_i      (req),
        .pmc_addr_i     (addr),
        .pmc_ea_b_i     (ea_b),
        .pmc_ack_o      (ack),
        .pmc_data_o     (data),
        .pmc_busy_o     (busy),
        .pmc_rom_cs_o   (rom_cs),
        .pmc_rom_addr_o (rom_addr),
        .pmc_rom_data_i (rom_q),
        .pmc_ale_o      (ale),
        .pmc_psen_b_o   (psen_b),
        .pmc_p0_a_o     (p0_a),
        .pmc_p0_en_o    (p0_en),
        .pmc_p2_a_o     (p2_a),
`ifdef EMC_PMC_EXT_WAIT_EN
        .pmc_p0_y_i     (p0_y),
        .pmc_wait_i     (wait_tb)
`else
        .pmc_p0_y_i     (p0_y)
`endif
    );

    always #5 clk = ~clk;

    // Registered ROM macro: data valid one clock after cs.
    initial forever begin
        @(posedge clk);
        if (rom_cs) rom_q <= rom[rom_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one fetch record (start edge, done edge, source) per accepted request.
    int          ecnt = 0;
    bit          m_act = 1'b0;
    bit          m_ext = 1'b0;
    int          m_n = 0, m_d = 0, m_ack_e = -1;
    logic [15:0] m_addr = 16'h0;
    logic [7:0]  m_dout = 8'h0, m_p0a = 8'h0, m_p2a = 8'h0;
    logic [11:0] m_romaddr = 12'h0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_act = 1'b0; m_ack_e = -1; m_dout = 8'h0;
            m_p0a = 8'h0; m_p2a = 8'h0; m_romaddr = 12'h0;
        end else begin
            ecnt++;
            if (m_act) begin
                if (ecnt == m_d) begin
                    if (m_ext && hold_now) m_d++;
                    else begin
                        m_act = 1'b0;
                        m_ack_e = ecnt;
                        m_dout = m_ext ? p0_y : rom[m_addr[11:0]];
                    end
                end
            end else if (req) begin
                m_act  = 1'b1;
                m_n    = ecnt;
                m_addr = addr;
                m_ext  = !(ea_b && addr < 16'h1000);
                m_d    = ecnt + (m_ext ? EXT_WAIT + 2 : 2);
                if (m_ext) begin m_p0a = addr[7:0]; m_p2a = addr[15:8]; end
                else m_romaddr = addr[11:0];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rom_cs) n_cs++;
        if (ale) n_ale++;
        if (!psen_b) n_psen++;
        if (ack) n_ack++;
        if (cmp_en) begin
            chk("ack",     {31'b0, ack},    {31'b0, m_ack_e == ecnt});
            chk("busy",    {31'b0, busy},   {31'b0, m_act});
            chk("rom_cs",  {31'b0, rom_cs}, {31'b0, m_act && !m_ext && ecnt == m_n});
            chk("ale",     {31'b0, ale},    {31'b0, m_act && m_ext && ecnt == m_n});
            chk("psen_b",  {31'b0, psen_b}, {31'b0, !(m_act && m_ext && ecnt > m_n)});
            chk("p0_en",   {24'b0, p0_en},  (m_act && m_ext && ecnt == m_n) ? 32'hFF : 32'h0);
            chk("data",    {24'b0, data},   {24'b0, m_dout});
            chk("p0_a",    {24'b0, p0_a},   {24'b0, m_p0a});
            chk("p2_a",    {24'b0, p2_a},   {24'b0, m_p2a});
            chk("rom_addr",{20'b0, rom_addr}, {20'b0, m_romaddr});
        end
    end

    task automatic do_fetch(input string nm, input logic [15:0] a, input logic ea, input logic [7:0] y,
                            input int hold, input int exp_lat, input logic [7:0] exp_d,
                            input int exp_cs, input int exp_ale, input int exp_psen);
        int lat, c0, a0, p0;
        @(posedge clk); #1;
        c0 = n_cs; a0 = n_ale; p0 = n_psen;
        addr = a; ea_b = ea; p0_y = y; req = 1'b1;
`ifdef EMC_PMC_EXT_WAIT_EN
        if (hold > 0) wait_tb = 1'b1;
`endif
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
`ifdef EMC_PMC_EXT_WAIT_EN
            if (hold > 0 && lat == EXT_WAIT + 1 + hold) wait_tb = 1'b0;
`endif
            if (ack) break;
        end
        chk({nm, "_lat"},  lat, exp_lat);
        chk({nm, "_data"}, {24'b0, data}, {24'b0, exp_d});
        @(negedge clk); #1;
        chk({nm, "_ncs"},   n_cs - c0,   exp_cs);
        chk({nm, "_nale"},  n_ale - a0,  exp_ale);
        chk({nm, "_npsen"}, n_psen - p0, exp_psen);
    endtask

    initial begin
        int gap, a0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'(i * 7 + 3);
        rom[12'h123] = 8'hA5;
        rom[12'h001] = 8'h11;
        rom[12'h002] = 8'h22;
        rom[12'hFFF] = 8'h3C;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_psen_b", {31'b0, psen_b}, 32'h1);
        chk("rst_busy",   {31'b0, busy},   32'h0);
        chk("rst_ack",    {31'b0, ack},    32'h0);
        chk("rst_data",   {24'b0, data},   32'h0);
        chk("rst_p0_en",  {24'b0, p0_en},  32'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        cmp_en = 1'b1;

        do_fetch("int123",  16'h0123, 1'b1, 8'h00, 0, 2, 8'hA5, 1, 0, 0);
        do_fetch("intFFF",  16'h0FFF, 1'b1, 8'h00, 0, 2, 8'h3C, 1, 0, 0);
        do_fetch("ext1000", 16'h1000, 1'b1, 8'h77, 0, 4, 8'h77, 0, 1, 3);
        do_fetch("ext1234", 16'h1234, 1'b1, 8'h5A, 0, 4, 8'h5A, 0, 1, 3);
        chk("hold_p0_a",     {24'b0, p0_a},     32'h34);
        chk("hold_p2_a",     {24'b0, p2_a},     32'h12);
        chk("hold_rom_addr", {20'b0, rom_addr}, 32'hFFF);
        do_fetch("ea0",     16'h0010, 1'b0, 8'hC3, 0, 4, 8'hC3, 0, 1, 3);

        // Back-to-back with req held and address changed mid-fetch.
        @(posedge clk); #1;
        addr = 16'h0001; ea_b = 1'b1; req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        addr = 16'h0002;
        gap = 0;
        while (!ack && gap < 40) begin @(posedge clk); #1; gap++; end
        chk("b2b_first_data", {24'b0, data}, 32'h11);
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
            if (gap == 1) req = 1'b0;
        end while (!ack && gap < 40);
        chk("b2b_gap",         gap, 3);
        chk("b2b_second_data", {24'b0, data}, 32'h22);

        // Asynchronous reset during the second PSEN_b cycle.
        @(posedge clk); #1;
        addr = 16'h2000; ea_b = 1'b1; p0_y = 8'h99; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        chk("pre_rst_psen_b", {31'b0, psen_b}, 32'h0);
        rst = 1'b1;
        #1;
        chk("async_psen_b", {31'b0, psen_b}, 32'h1);
        chk("async_p0_en",  {24'b0, p0_en},  32'h0);
        chk("async_busy",   {31'b0, busy},   32'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        a0 = n_ack;
        repeat (8) @(posedge clk);
        #2;
        chk("no_ack_after_rst", n_ack - a0, 0);

`ifdef EMC_PMC_EXT_WAIT_EN
        do_fetch("wait4", 16'h3456, 1'b1, 8'hE1, 4, 8, 8'hE1, 0, 1, 7);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
